combo_lock_fsm: RTL and testbench

Four-digit combination-entry state machine that drives the `complete[7:0]` bus consumed by the LED blink stage. It takes raw switch/button inputs from the board, synchronises them, and checks the entered sequence against a compiled-in code. It asserts `complete` when the code is correct. Repeated failures trigger a timed lockout. All logic runs on the 1 MHz lock clock.

---
 rtl/lock_pkg.sv | 24 ++
 rtl/btn_sync_edge.sv | 36 +++
 rtl/combo_lock_fsm.sv | 183 ++++++++++++++++++
 tb/tb_combo_lock_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and constants for the combination lock
// Purpose: state encoding, complete-bus levels, code length and a helper
//          that picks one digit of the compiled-in code.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } lock_state_e;

  localparam logic [7:0] COMPLETE_ON  = 8'hFF;
  localparam logic [7:0] COMPLETE_OFF = 8'h00;
  localparam int         CODE_LEN     = 4;

  // Digit 0 is the most significant nibble; shift by 4*(3-idx), and 3-idx == ~idx.
  function automatic logic [3:0] code_digit(input logic [15:0] code, input logic [1:0] idx);
    logic [15:0] shifted;
    shifted = code >> {~idx, 2'b00};
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser with rising-edge pulse
// Purpose: bring an asynchronous, pre-debounced button into the clock domain
//          and emit a single-cycle pulse per press.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   btn_i   - raw asynchronous button level
//   pulse_o - one-cycle pulse on each synchronised rising edge
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // All flops reset to 1 so a button held through reset looks like "already
  // pressed" and produces no pulse once reset is released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - four-digit combination lock with timed lockout
// Purpose: synchronise switch/button inputs, check the entered sequence
//          against CODE, drive the complete bus and lock out after repeated
//          failures.
// Ports:
//   lock_clk   - 1 MHz clock
//   lock_rst   - synchronous active-high reset
//   digit      - raw digit switches (async)
//   enter      - raw enter button (async, active-high)
//   clear      - raw clear button (async, active-high)
//   complete   - 8'hFF while unlocked, else 8'h00
//   progress   - digits accepted in the current attempt (4 when unlocked)
//   fail_cnt   - consecutive failed attempts
//   locked_out - high during lockout
module combo_lock_fsm
  import lock_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 5_000_000,
  parameter int          UNLOCK_CYCLES  = 10_000_000
) (
  input  logic       lock_clk,
  input  logic       lock_rst,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  output logic [7:0] complete,
  output logic [2:0] progress,
  output logic [1:0] fail_cnt,
  output logic       locked_out
);

  localparam int TIMER_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  // Timer is loaded with N-1 and the state exits on the edge where it reads 0,
  // giving exactly N cycles in the timed state.
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'((UNLOCK_CYCLES == 0) ? 0 : UNLOCK_CYCLES - 1);
  localparam logic [1:0]    MAX_FAIL_L   = 2'(MAX_FAIL);
  localparam logic [2:0]    LAST_IDX     = 3'(CODE_LEN - 1);

  logic enter_p;
  logic clear_p;

  btn_sync_edge u_enter_sync (
    .clk_i   (lock_clk),
    .rst_i   (lock_rst),
    .btn_i   (enter),
    .pulse_o (enter_p)
  );

  btn_sync_edge u_clear_sync (
    .clk_i   (lock_clk),
    .rst_i   (lock_rst),
    .btn_i   (clear),
    .pulse_o (clear_p)
  );

  logic [3:0] dig1_q;
  logic [3:0] dig2_q;

  always_ff @(posedge lock_clk) begin
    if (lock_rst) begin
      dig1_q <= 4'd0;
      dig2_q <= 4'd0;
    end else begin
      dig1_q <= digit;
      dig2_q <= dig1_q;
    end
  end

  lock_state_e   state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          mis_q, mis_d;
  logic [1:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    complete_q;
  logic [2:0]    progress_q;
  logic          locked_q;

  logic          miss;
  logic [1:0]    fail_inc;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    miss     = mis_q | (dig2_q != code_digit(CODE, idx_q[1:0]));
    fail_inc = fail_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (clear_p) begin
          idx_d = 3'd0;
          mis_d = 1'b0;
        end else if (enter_p) begin
          mis_d   = miss;
          idx_d   = 3'd1;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (clear_p) begin
          idx_d   = 3'd0;
          mis_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (enter_p) begin
          if (idx_q == LAST_IDX) begin
            idx_d = 3'd0;
            mis_d = 1'b0;
            if (!miss) begin
              fail_d  = 2'd0;
              timer_d = UNLOCK_LOAD;
              state_d = ST_UNLOCKED;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == MAX_FAIL_L) begin
                timer_d = LOCKOUT_LOAD;
                state_d = ST_LOCKOUT;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            idx_d = idx_q + 3'd1;
            mis_d = miss;
          end
        end
      end
      ST_UNLOCKED: begin
        if (clear_p) begin
          state_d = ST_IDLE;
        end else if (UNLOCK_CYCLES != 0) begin
          if (timer_q == '0) state_d = ST_IDLE;
          else               timer_d = timer_q - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d  = 2'd0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge lock_clk) begin
    if (lock_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      mis_q      <= 1'b0;
      fail_q     <= 2'd0;
      timer_q    <= '0;
      complete_q <= COMPLETE_OFF;
      progress_q <= 3'd0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mis_q      <= mis_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      // Outputs are decoded from the next state so they move on the same edge.
      complete_q <= (state_d == ST_UNLOCKED) ? COMPLETE_ON : COMPLETE_OFF;
      progress_q <= (state_d == ST_UNLOCKED) ? 3'(CODE_LEN) :
                    (state_d == ST_LOCKOUT)  ? 3'd0 : idx_d;
      locked_q   <= (state_d == ST_LOCKOUT);
    end
  end

  assign complete   = complete_q;
  assign progress   = progress_q;
  assign fail_cnt   = fail_q;
  assign locked_out = locked_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - directed self-checking bench for combo_lock_fsm
module tb_combo_lock_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit;
  logic       enter;
  logic       clear;

  logic [7:0] complete_a, complete_b;
  logic [2:0] progress_a, progress_b;
  logic [1:0] fail_a, fail_b;
  logic       locked_a, locked_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  combo_lock_fsm #(
    .CODE(16'h1234), .MAX_FAIL(3), .LOCKOUT_CYCLES(20), .UNLOCK_CYCLES(30)
  ) dut_a (
    .lock_clk(clk), .lock_rst(rst), .digit(digit), .enter(enter), .clear(clear),
    .complete(complete_a), .progress(progress_a), .fail_cnt(fail_a), .locked_out(locked_a)
  );

  combo_lock_fsm #(
    .CODE(16'h1234), .MAX_FAIL(3), .LOCKOUT_CYCLES(20), .UNLOCK_CYCLES(0)
  ) dut_b (
    .lock_clk(clk), .lock_rst(rst), .digit(digit), .enter(enter), .clear(clear),
    .complete(complete_b), .progress(progress_b), .fail_cnt(fail_b), .locked_out(locked_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the DUT two edges after enter rises: one more edge applies the press.
  task automatic start_press(input logic [3:0] d);
    @(negedge clk);
    digit = d;
    repeat (3) @(negedge clk);
    enter = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_press();
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    start_press(d);
    finish_press();
  endtask

  task automatic press_code(input logic [15:0] code);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; digit = 4'd0; enter = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_complete", complete_a, 8'h00);
    check("rst_progress", progress_a, 0);
    check("rst_fail", fail_a, 0);
    check("rst_locked", locked_a, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Correct code with latency and auto-relock timing.
    press(4'd1); check("ok_prog1", progress_a, 1);
    press(4'd2); check("ok_prog2", progress_a, 2);
    press(4'd3); check("ok_prog3", progress_a, 3);
    start_press(4'd4);
    check("ok_latency_2edges", complete_a, 8'h00);
    finish_press();
    check("ok_complete", complete_a, 8'hFF);
    check("ok_prog4", progress_a, 4);
    check("ok_fail0", fail_a, 0);
    repeat (29) @(negedge clk);
    check("relock_last_cycle", complete_a, 8'hFF);
    @(negedge clk);
    check("relock_complete", complete_a, 8'h00);
    check("relock_progress", progress_a, 0);

    // One wrong code.
    press_code(16'h1235);
    check("wrong_complete", complete_a, 8'h00);
    check("wrong_fail1", fail_a, 1);
    check("wrong_progress", progress_a, 0);

    // Correct code resets fail count; clear while unlocked.
    press_code(16'h1234);
    check("ok2_complete", complete_a, 8'hFF);
    check("ok2_fail0", fail_a, 0);
    @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_unlk_pending", complete_a, 8'hFF);
    @(negedge clk);
    clear = 1'b0;
    check("clr_unlk_complete", complete_a, 8'h00);

    // Three wrong codes into lockout.
    press_code(16'h9999); check("lo_fail1", fail_a, 1);
    press_code(16'h9999); check("lo_fail2", fail_a, 2);
    press_code(16'h9999);
    check("lo_locked", locked_a, 1);
    check("lo_fail3", fail_a, 3);
    check("lo_progress", progress_a, 0);
    press(4'd1);
    check("lo_ignore1", progress_a, 0);
    press(4'd2);
    check("lo_ignore2", progress_a, 0);
    check("lo_ignore_cmp", complete_a, 8'h00);
    repeat (5) @(negedge clk);
    check("lo_last_cycle", locked_a, 1);
    @(negedge clk);
    check("lo_end_locked", locked_a, 0);
    check("lo_end_fail", fail_a, 0);
    press_code(16'h1234);
    check("post_lo_unlock", complete_a, 8'hFF);
    pulse_clear();
    check("post_lo_clear", complete_a, 8'h00);

    // Clear mid-entry keeps fail count and restarts the attempt.
    press(4'd1);
    press(4'd2);
    pulse_clear();
    check("clr_entry_prog", progress_a, 0);
    check("clr_entry_fail", fail_a, 0);
    press_code(16'h1234);
    check("clr_entry_unlock", complete_a, 8'hFF);
    pulse_clear();

    // Clear and enter in the same cycle: clear wins.
    press(4'd1);
    check("both_pre_prog", progress_a, 1);
    @(negedge clk);
    digit = 4'd2;
    repeat (3) @(negedge clk);
    enter = 1'b1;
    clear = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    clear = 1'b0;
    check("both_prog", progress_a, 0);
    repeat (2) @(negedge clk);
    press(4'd1);
    check("both_after_prog", progress_a, 1);
    pulse_clear();

    // Reset mid-entry after a failed attempt.
    press_code(16'h9999);
    check("rst_mid_fail", fail_a, 1);
    press(4'd1); press(4'd2); press(4'd3);
    check("rst_mid_prog3", progress_a, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_progress", progress_a, 0);
    check("rst_mid_fail0", fail_a, 0);
    check("rst_mid_complete", complete_a, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Enter held through reset release gives no pulse.
    @(negedge clk);
    rst = 1'b1;
    enter = 1'b1;
    digit = 4'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("held_enter_prog", progress_a, 0);
    enter = 1'b0;
    repeat (3) @(negedge clk);

    // UNLOCK_CYCLES=0 instance stays unlocked until clear.
    press_code(16'h1234);
    check("u0_complete", complete_b, 8'hFF);
    check("u0_progress", progress_b, 4);
    repeat (1000) @(negedge clk);
    check("u0_held", complete_b, 8'hFF);
    check("u0_locked", locked_b, 0);
    check("u0_fail", fail_b, 0);
    check("timed_relocked", complete_a, 8'h00);
    pulse_clear();
    check("u0_cleared", complete_b, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
